// File: rtl/sw_debounce.sv
// sw_debounce: per-bit switch debouncer with 2-flop input sync, reset synchronizer,
// and registered rise/fall/any-change pulses.
module sw_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_WIDTH       = 19,
   parameter int N_SW            = 4
) (
   input  logic            clk_clk,
   input  logic            reset_reset_n,
   input  logic [N_SW-1:0] sw_raw,
   output logic [N_SW-1:0] sw_stable,
   output logic [N_SW-1:0] sw_rise,
   output logic [N_SW-1:0] sw_fall,
   output logic            sw_any_change
);
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {STABLE, COUNTING} state_t;

   if (DEBOUNCE_CYCLES < 2 || 64'(DEBOUNCE_CYCLES) > (64'(1) << CNT_WIDTH)) begin : g_bad_params
      $error("sw_debounce: DEBOUNCE_CYCLES must lie in [2, 2**CNT_WIDTH]");
   end

   logic [1:0]      r_rst_sync;
   logic            w_rst_n;
   logic [N_SW-1:0] r_sync1;
   logic [N_SW-1:0] r_sync2;
   logic [N_SW-1:0] r_stable;
   logic [N_SW-1:0] r_rise;
   logic [N_SW-1:0] r_fall;
   logic            r_any;
   logic [N_SW-1:0] w_accept;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) r_rst_sync <= '0;
      else                r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n = r_rst_sync[1];

   // Input synchronizers run off the raw reset so they start sampling while the
   // reset synchronizer is still releasing; this keeps power-up latency equal to
   // the normal step latency.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= sw_raw;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar g = 0; g < N_SW; g++) begin : g_bit
      state_t               r_state;
      state_t               w_state_nxt;
      logic [CNT_WIDTH-1:0] r_cnt;
      logic [CNT_WIDTH-1:0] w_cnt_nxt;
      logic                 w_differ;
      logic                 w_done;

      assign w_differ = r_sync2[g] ^ r_stable[g];

      always_ff @(posedge clk_clk or negedge w_rst_n) begin
         if (!w_rst_n) begin
            r_state <= STABLE;
            r_cnt   <= '0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
         end
      end

      always_comb begin
         w_state_nxt = (w_differ && !w_done) ? COUNTING : STABLE;
      end

      always_comb begin
         w_done    = (r_state == COUNTING) && w_differ && (r_cnt == LAST);
         w_cnt_nxt = (w_differ && !w_done) ? r_cnt + CNT_WIDTH'(1) : '0;
      end

      assign w_accept[g] = w_done;
   end

   always_ff @(posedge clk_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_stable <= '0;
         r_rise   <= '0;
         r_fall   <= '0;
         r_any    <= 1'b0;
      end else begin
         r_stable <= r_stable ^ w_accept;
         r_rise   <= w_accept & ~r_stable;
         r_fall   <= w_accept & r_stable;
         r_any    <= |w_accept;
      end
   end

   assign sw_stable     = r_stable;
   assign sw_rise       = r_rise;
   assign sw_fall       = r_fall;
   assign sw_any_change = r_any;
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed scenarios plus randomized traffic, checked against a
// sliding-window model of the sampled switch history.
module tb_sw_debounce;
   localparam int D = 8;
   localparam int W = 3;
   localparam int N = 4;
   localparam int R = 32;

   logic         clk = 1'b0;
   logic         reset_reset_n = 1'b0;
   logic [N-1:0] sw_raw = '0;
   logic [N-1:0] sw_stable;
   logic [N-1:0] sw_rise;
   logic [N-1:0] sw_fall;
   logic         sw_any_change;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sw_debounce #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(W), .N_SW(N)) dut (
      .clk_clk      (clk),
      .reset_reset_n(reset_reset_n),
      .sw_raw       (sw_raw),
      .sw_stable    (sw_stable),
      .sw_rise      (sw_rise),
      .sw_fall      (sw_fall),
      .sw_any_change(sw_any_change)
   );

   // Reference: a bit flips when the last D edges were all live (reset released
   // for 2 prior edges) and all saw a raw sample (two edges old) opposite to it.
   logic [N-1:0] raw_h [R];
   bit           rs_h  [R];
   int           cyc = 0;
   logic [N-1:0] m_st = '0;
   logic [N-1:0] m_rise = '0;
   logic [N-1:0] m_fall = '0;
   logic         m_any;

   assign m_any = |(m_rise | m_fall);

   always @(posedge clk) begin
      logic [N-1:0] nxt;
      bit ok;
      int k;
      raw_h[cyc % R] = sw_raw;
      rs_h[cyc % R]  = reset_reset_n;
      if (!reset_reset_n) begin
         m_st = '0; m_rise = '0; m_fall = '0;
      end else begin
         nxt = m_st;
         for (int b = 0; b < N; b++) begin
            ok = (cyc >= D + 1);
            for (int j = 0; j < D; j++) begin
               k = cyc - j;
               if (ok) ok = rs_h[k % R] && rs_h[(k-1) % R] && rs_h[(k-2) % R] &&
                            (raw_h[(k-2) % R][b] != m_st[b]);
            end
            if (ok) nxt[b] = ~m_st[b];
         end
         m_rise = nxt & ~m_st;
         m_fall = ~nxt & m_st;
         m_st   = nxt;
      end
      cyc++;
   end

   always @(negedge reset_reset_n) begin
      m_st = '0; m_rise = '0; m_fall = '0;
   end

   always @(negedge clk) begin
      n_tests++;
      if ({sw_stable, sw_rise, sw_fall, sw_any_change} !== {m_st, m_rise, m_fall, m_any}) begin
         n_fail++;
         $display("FAIL model cyc %0d: got st=%b r=%b f=%b a=%b, expected st=%b r=%b f=%b a=%b",
                  cyc, sw_stable, sw_rise, sw_fall, sw_any_change, m_st, m_rise, m_fall, m_any);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      sw_raw = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if ({sw_stable, sw_rise, sw_fall, sw_any_change} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got st=%b r=%b f=%b a=%b, expected all zero",
                     sw_stable, sw_rise, sw_fall, sw_any_change);
         end
      end
      reset_reset_n = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         tick();
         n_tests++;
         if (sw_stable !== ((j >= 10) ? 4'b0010 : 4'b0000) || sw_rise !== ((j == 10) ? 4'b0010 : 4'b0000)) begin
            n_fail++;
            $display("FAIL held_through_reset j=%0d: got st=%b r=%b, expected st=%b r=%b", j,
                     sw_stable, sw_rise, (j >= 10) ? 4'b0010 : 4'b0000, (j == 10) ? 4'b0010 : 4'b0000);
         end
      end
      sw_raw = '0;
      repeat (12) tick();
   endtask

   task automatic test_clean_step();
      logic [N-1:0] es, er;
      sw_raw = 4'b0001;
      for (int i = 1; i <= 12; i++) begin
         tick();
         es = (i >= 10) ? 4'b0001 : 4'b0000;
         er = (i == 10) ? 4'b0001 : 4'b0000;
         n_tests++;
         if ({sw_stable, sw_rise, sw_fall, sw_any_change} !== {es, er, 4'b0000, (i == 10)}) begin
            n_fail++;
            $display("FAIL clean_step i=%0d: got st=%b r=%b f=%b a=%b, expected st=%b r=%b f=0000 a=%b",
                     i, sw_stable, sw_rise, sw_fall, sw_any_change, es, er, (i == 10));
         end
      end
      sw_raw = '0;
      repeat (12) tick();
   endtask

   task automatic test_glitch();
      sw_raw[2] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) sw_raw[2] = 1'b0;
         tick();
         n_tests++;
         if ({sw_stable, sw_rise, sw_fall} !== 12'd0) begin
            n_fail++;
            $display("FAIL glitch i=%0d: got st=%b r=%b f=%b, expected all zero",
                     i, sw_stable, sw_rise, sw_fall);
         end
      end
   endtask

   task automatic test_bounce();
      int pulses = 0;
      int at = -1;
      for (int i = 0; i < 30; i++) begin
         sw_raw[3] = ((i / 3) % 2) == 0;
         tick();
         if (sw_rise[3]) pulses++;
      end
      sw_raw[3] = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (sw_rise[3]) begin
            pulses++;
            at = i;
         end
      end
      n_tests++;
      if (pulses != 1 || at != 10 || sw_stable[3] !== 1'b1) begin
         n_fail++;
         $display("FAIL bounce: got %0d pulses at %0d st3=%b, expected 1 pulse at 10 st3=1",
                  pulses, at, sw_stable[3]);
      end
      sw_raw = '0;
      repeat (12) tick();
   endtask

   task automatic test_simultaneous();
      logic [N-1:0] es;
      sw_raw = 4'b1010;
      repeat (12) tick();
      n_tests++;
      if (sw_stable !== 4'b1010) begin
         n_fail++;
         $display("FAIL simul_setup: got st=%b, expected st=1010", sw_stable);
      end
      sw_raw = 4'b0101;
      for (int i = 1; i <= 12; i++) begin
         tick();
         es = (i >= 10) ? 4'b0101 : 4'b1010;
         n_tests++;
         if ({sw_stable, sw_rise, sw_fall, sw_any_change} !==
             {es, (i == 10) ? 4'b0101 : 4'b0000, (i == 10) ? 4'b1010 : 4'b0000, (i == 10)}) begin
            n_fail++;
            $display("FAIL simultaneous i=%0d: got st=%b r=%b f=%b a=%b, expected st=%b with pulses only at i=10",
                     i, sw_stable, sw_rise, sw_fall, sw_any_change, es);
         end
      end
      sw_raw = '0;
      repeat (12) tick();
   endtask

   task automatic test_reset_mid_count();
      sw_raw = 4'b0001;
      repeat (7) tick();
      reset_reset_n = 1'b0;
      #1;
      n_tests++;
      if ({sw_stable, sw_rise, sw_fall, sw_any_change} !== 13'd0) begin
         n_fail++;
         $display("FAIL async_reset: got st=%b r=%b f=%b a=%b, expected all zero",
                  sw_stable, sw_rise, sw_fall, sw_any_change);
      end
      repeat (3) tick();
      reset_reset_n = 1'b1;
      for (int j = 1; j <= 14; j++) begin
         tick();
         n_tests++;
         if (sw_stable !== ((j >= 10) ? 4'b0001 : 4'b0000) || sw_rise !== ((j == 10) ? 4'b0001 : 4'b0000) ||
             sw_any_change !== (j == 10)) begin
            n_fail++;
            $display("FAIL reset_mid_count j=%0d: got st=%b r=%b a=%b, expected rise only at j=10",
                     j, sw_stable, sw_rise, sw_any_change);
         end
      end
      sw_raw = '0;
      repeat (12) tick();
   endtask

   task automatic test_random();
      for (int s = 0; s < 80; s++) begin
         sw_raw = N'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            reset_reset_n = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            reset_reset_n = 1'b1;
         end
         repeat ($urandom_range(1, 12)) tick();
      end
      repeat (15) tick();
   endtask

   initial begin
      test_reset();
      test_clean_step();
      test_glitch();
      test_bounce();
      test_simultaneous();
      test_reset_mid_count();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk_clk and reset_reset_n.
REQ-002 Parameter DEBOUNCE_CYCLES SHALL default to 500000 and SHALL be the consecutive clk_clk cycles of disagreement required to accept a new level (10 ms at 50 MHz).
REQ-003 Parameter CNT_WIDTH SHALL default to 19 and SHALL be the per-bit counter width.
REQ-004 Parameter N_SW SHALL default to 4 and SHALL be the number of switch bits.
REQ-005 clk_clk  in  1  system clock.
REQ-006 reset_reset_n  in  1  asynchronous active-low reset.
REQ-007 sw_raw  in  N_SW  raw board switch pins, asynchronous to clk_clk.
REQ-008 sw_stable  out  N_SW  debounced level, driving the system sw_con_export input.
REQ-009 sw_rise  out  N_SW  one-cycle pulse per bit when sw_stable goes 0->1.
REQ-010 sw_fall  out  N_SW  one-cycle pulse per bit when sw_stable goes 1->0.
REQ-011 sw_any_change  out  1  one-cycle pulse, OR of all sw_rise and sw_fall bits.

Function
REQ-012 Each sw_raw bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-013 Each bit SHALL have an independent 2-state FSM: STABLE (sync2 == sw_stable) and COUNTING (sync2 != sw_stable).
REQ-014 In STABLE the bit counter SHALL hold at 0; the FSM enters COUNTING on the first cycle sync2 differs, with the counter incrementing from 0.
REQ-015 In COUNTING, if sync2 returns to sw_stable, the counter SHALL clear to 0 and the FSM SHALL return to STABLE in the same cycle (glitch rejected, no output change).
REQ-016 In COUNTING, on the edge where the counter equals DEBOUNCE_CYCLES-1 and sync2 still differs, sw_stable SHALL take sync2, the counter SHALL clear, the FSM SHALL return to STABLE, and the matching rise/fall pulse SHALL assert for exactly the next cycle.
REQ-017 Total latency from a clean sw_raw step (meeting setup) to sw_stable change SHALL be exactly 2 + DEBOUNCE_CYCLES clk_clk cycles.
REQ-018 sw_rise, sw_fall and sw_any_change SHALL be registered, mutually consistent, and never high for more than one consecutive cycle per transition.
REQ-019 Bits SHALL be fully independent; simultaneous transitions on several bits SHALL yield simultaneous pulses and a single-cycle sw_any_change.
REQ-020 The counter SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap-around); legal parameters are 2 <= DEBOUNCE_CYCLES <= 2^CNT_WIDTH, checked by an elaboration-time assertion.
REQ-021 sw_raw toggling with a period shorter than DEBOUNCE_CYCLES SHALL leave sw_stable unchanged indefinitely.

Reset
REQ-022 While reset_reset_n is low: sync1, sync2, sw_stable, sw_rise, sw_fall, sw_any_change and all counters SHALL be 0 and all FSMs in STABLE, asynchronously upon assertion.
REQ-023 Deassertion SHALL be synchronized inside the block (2-flop reset synchronizer), releasing on a clk_clk rising edge.
REQ-024 A switch held at 1 through reset SHALL be accepted 2 + DEBOUNCE_CYCLES cycles after release and SHALL produce one sw_rise pulse.
REQ-025 Reset asserted mid-COUNTING SHALL discard the count; no pulse SHALL be generated for the aborted transition.

Verification (DEBOUNCE_CYCLES=8)
REQ-026 Clean step: sw_raw 0000->0001 held -> sw_stable=0001 exactly 10 cycles later, sw_rise=0001 and sw_any_change=1 for one cycle, sw_fall=0000 throughout.
REQ-027 Glitch: sw_raw[2] high for 5 cycles then low -> sw_stable, sw_rise, sw_fall stay 0.
REQ-028 Bounce: sw_raw[3] toggles every 3 cycles for 30 cycles, then holds 1 -> exactly one sw_rise[3] pulse, 10 cycles after the final edge.
REQ-029 Simultaneous: sw_stable=1010, sw_raw 1010->0101 -> after 10 cycles sw_stable=0101, sw_rise=0101, sw_fall=1010 and sw_any_change=1 in the same single cycle.
REQ-030 Reset mid-count: assert reset_reset_n low at count 5 of a 0->1 transition, hold sw_raw=0001 -> outputs 0 during reset; after release, sw_stable=0001 after 2 + 8 cycles with one sw_rise pulse.
